tlm_pair_sequencer: RTL and testbench

//  Ping-pong batch buffer and sequencer between the DPI/TLM loader and the bfm operand inputs.
//  The loader writes batches of (A,B) byte pairs into one bank while the other bank streams to the bfm,
//  one pair per accepted beat. Counts BATCH_NUM batches, then raises done.

---
 rtl/tlm_pair_sequencer.sv | 149 ++++++++++++++
 tb/tb_tlm_pair_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlm_pair_sequencer.sv
`default_nettype none
// ============================================================================
// tlm_pair_sequencer : ping-pong (A,B) pair buffer streaming batches to the bfm
// Revision: 1.0
// ============================================================================
module tlm_pair_sequencer #(
  parameter int ITEM_WIDTH = 8,
  parameter int DEPTH      = 1000,
  parameter int BATCH_NUM  = 2000
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ITEM_WIDTH-1:0] wr_a_i,
  input  logic [ITEM_WIDTH-1:0] wr_b_i,
  input  logic                  wr_last_i,
  output logic                  fill_req_o,
  output logic [ITEM_WIDTH-1:0] a_o,
  output logic [ITEM_WIDTH-1:0] b_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BATCH_NUM + 1);
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [BW-1:0] BATCH_MAX = BW'(BATCH_NUM);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {B_FREE = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2} bank_t;

  state_t                  state, state_nxt;
  bank_t                   bank_st  [2];
  logic [AW-1:0]           last_idx [2];
  logic [2*ITEM_WIDTH-1:0] mem      [2][DEPTH];
  logic                    wr_bank, rd_bank;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [BW-1:0]           wr_batches, rd_batches;
  logic                    clear, wr_beat, wr_close, out_adv, rd_load, rd_last;

  always_comb begin
    state_nxt  = state;
    clear      = 1'b0;
    wr_ready_o = 1'b0;
    fill_req_o = 1'b0;
    done_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_RUN;
          clear     = 1'b1;
        end
      end
      S_RUN: begin
        wr_ready_o = (bank_st[wr_bank] != B_FULL) && (wr_batches < BATCH_MAX);
        fill_req_o = (bank_st[wr_bank] == B_FREE) && (wr_ptr == '0) && (wr_batches < BATCH_MAX);
        // Hold RUN until the final pair has actually left the output stage.
        if ((rd_batches == BATCH_MAX) && (!out_valid_o || out_ready_i)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          state_nxt = S_RUN;
          clear     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign wr_beat  = wr_valid_i && wr_ready_o;
  assign wr_close = wr_beat && (wr_last_i || (wr_ptr == LAST_PTR));
  assign out_adv  = !out_valid_o || out_ready_i;
  assign rd_load  = out_adv && (bank_st[rd_bank] == B_FULL);
  assign rd_last  = (rd_ptr == last_idx[rd_bank]);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (wr_beat) mem[wr_bank][wr_ptr] <= {wr_a_i, wr_b_i};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bank_st[0]  <= B_FREE;
      bank_st[1]  <= B_FREE;
      last_idx[0] <= '0;
      last_idx[1] <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_batches  <= '0;
      rd_batches  <= '0;
      out_valid_o <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
    end else if (clear) begin
      bank_st[0]  <= B_FREE;
      bank_st[1]  <= B_FREE;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_batches  <= '0;
      rd_batches  <= '0;
      out_valid_o <= 1'b0;
    end else begin
      // A write never targets a FULL bank and a read only drains a FULL one,
      // so the two bank_st updates below always address different banks.
      if (wr_beat) begin
        if (wr_close) begin
          bank_st[wr_bank]  <= B_FULL;
          last_idx[wr_bank] <= wr_ptr;
          wr_ptr            <= '0;
          wr_bank           <= !wr_bank;
          wr_batches        <= wr_batches + 1'b1;
        end else begin
          bank_st[wr_bank]  <= B_FILLING;
          wr_ptr            <= wr_ptr + 1'b1;
        end
      end
      if (out_adv) begin
        out_valid_o <= rd_load;
        if (rd_load) begin
          {a_o, b_o} <= mem[rd_bank][rd_ptr];
          if (rd_last) begin
            bank_st[rd_bank] <= B_FREE;
            rd_ptr           <= '0;
            rd_bank          <= !rd_bank;
            rd_batches       <= rd_batches + 1'b1;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlm_pair_sequencer.sv
`default_nettype none
// Bench for tlm_pair_sequencer: queue-based model compared every cycle plus literal pins.
module tb_tlm_pair_sequencer;

  localparam int IW    = 8;
  localparam int DEPTH = 4;
  localparam int BN    = 2;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic          start = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] wr_a = '0;
  logic [IW-1:0] wr_b = '0;
  logic          wr_last = 1'b0;
  logic          fill_req;
  logic [IW-1:0] a_o, b_o;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic          ready_fixed = 1'b1;
  logic          rand_mode = 1'b0;
  logic          rnd_bit = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp1 [3] = '{16'h1121, 16'h1222, 16'h1323};
  logic [15:0] exp3 [4] = '{16'h5161, 16'h5262, 16'h5363, 16'h5464};
  logic [15:0] exp2 [8] = '{16'h7191, 16'h7292, 16'h7393, 16'h7494,
                            16'h7595, 16'h7696, 16'h7797, 16'h7898};

  tlm_pair_sequencer #(.ITEM_WIDTH(IW), .DEPTH(DEPTH), .BATCH_NUM(BN)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_a_i(wr_a), .wr_b_i(wr_b), .wr_last_i(wr_last),
    .fill_req_o(fill_req), .a_o(a_o), .b_o(b_o),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign out_ready = rand_mode ? rnd_bit : ready_fixed;

  // ---------------- behavioural model: batches as queues ----------------
  int            m_st = 0;        // 0 idle, 1 run, 2 done
  int            m_wrb = 0;       // batches closed by the loader
  int            m_rdb = 0;       // batches whose last pair reached the output
  int            m_cu = 0;        // closed batches not yet fully handed to the output
  logic          m_valid = 1'b0;
  logic [IW-1:0] m_a = '0;
  logic [IW-1:0] m_b = '0;
  logic [16:0]   pend [$];        // {last_of_batch, a, b} ready to stream
  logic [15:0]   cur  [$];        // open batch being loaded

  initial begin : model
    bit          wr_rdy, adv;
    logic [16:0] p;
    forever begin
      @(posedge clk or negedge reset_ni);
      if (!reset_ni) begin
        m_st = 0; m_wrb = 0; m_rdb = 0; m_cu = 0;
        m_valid = 1'b0; m_a = '0; m_b = '0;
        pend.delete(); cur.delete();
      end else begin
        wr_rdy = (m_st == 1) && (m_wrb < BN) && (m_cu < 2);
        adv    = !m_valid || out_ready;
        if (m_st != 1 && start) begin
          m_st = 1; m_wrb = 0; m_rdb = 0; m_cu = 0; m_valid = 1'b0;
          pend.delete(); cur.delete();
        end else begin
          if (m_st == 1 && m_rdb == BN && adv) m_st = 2;
          if (adv) begin
            if (pend.size() > 0) begin
              p = pend.pop_front();
              {m_a, m_b} = p[15:0];
              m_valid = 1'b1;
              if (p[16]) begin m_cu--; m_rdb++; end
            end else begin
              m_valid = 1'b0;
            end
          end
          if (wr_valid && wr_rdy) begin
            cur.push_back({wr_a, wr_b});
            if (wr_last || cur.size() == DEPTH) begin
              foreach (cur[i]) pend.push_back({(i == cur.size() - 1), cur[i]});
              cur.delete();
              m_cu++; m_wrb++;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  initial begin : compare
    logic m_rdy, m_fill;
    forever begin
      @(negedge clk);
      if (reset_ni) begin
        m_rdy  = (m_st == 1) && (m_wrb < BN) && (m_cu < 2);
        m_fill = m_rdy && (cur.size() == 0);
        check("cycle", {12'd0, wr_ready, fill_req, done, out_valid, a_o, b_o},
                       {12'd0, m_rdy, m_fill, (m_st == 2), m_valid, m_a, m_b});
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic wr_pair(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic last);
    int n = 0;
    wr_valid = 1'b1; wr_a = a; wr_b = b; wr_last = last;
    while (!wr_ready && n < 200) begin @(negedge clk); n++; end
    check("wr_accept", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_fill_req", {30'd0, fill_req, done}, 32'b10);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    check("reset_outputs", {12'd0, wr_ready, fill_req, done, out_valid, a_o, b_o}, 32'd0);
    reset_ni = 1'b1;
    @(negedge clk);
    check("idle_no_fill", {31'd0, fill_req}, 32'd0);

    // 3-pair batch then a 2-pair batch; close-to-output latency of one cycle
    do_start();
    wr_pair(8'h11, 8'h21, 1'b0);
    wr_pair(8'h12, 8'h22, 1'b0);
    wr_pair(8'h13, 8'h23, 1'b1);
    check("close_latency", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_stream", {15'd0, out_valid, a_o, b_o}, {15'd0, 1'b1, exp1[i]});
    end
    wr_pair(8'h31, 8'h41, 1'b0);
    wr_pair(8'h32, 8'h42, 1'b1);
    wait_done();

    // writes refused in DONE, restart clears
    wr_valid = 1'b1; wr_a = 8'hEE; wr_b = 8'hEF; wr_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("done_wr_ready", {31'd0, wr_ready}, 32'd0);
      @(negedge clk);
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    check("done_hold", {31'd0, done}, 32'd1);
    do_start();

    // implicit close at DEPTH pairs; next batch goes to the other (free) bank
    for (int i = 0; i < 4; i++) wr_pair(8'h51 + 8'(i), 8'h61 + 8'(i), 1'b0);
    check("implicit_close", {29'd0, wr_ready, fill_req, out_valid}, 32'b110);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_stream", {15'd0, out_valid, a_o, b_o}, {15'd0, 1'b1, exp3[i]});
    end
    wr_pair(8'h55, 8'h65, 1'b1);
    wait_done();

    // both banks filled while stalled, then a gap-free drain
    ready_fixed = 1'b0;
    do_start();
    for (int i = 0; i < 8; i++) wr_pair(8'h71 + 8'(i), 8'h91 + 8'(i), 1'b0);
    check("both_full", {13'd0, wr_ready, fill_req, out_valid, a_o, b_o}, {13'd0, 3'b001, 16'h7191});
    repeat (3) @(negedge clk);
    ready_fixed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_stream", {15'd0, out_valid, a_o, b_o}, {15'd0, 1'b1, exp2[i]});
      @(negedge clk);
    end
    check("t2_done", {31'd0, done}, 32'd1);

    // random back-pressure
    rand_mode = 1'b1;
    do_start();
    for (int i = 0; i < 3; i++) wr_pair(8'hA1 + 8'(i), 8'hB1 + 8'(i), (i == 2));
    for (int i = 0; i < 4; i++) wr_pair(8'hC1 + 8'(i), 8'hD1 + 8'(i), 1'b0);
    wait_done();
    rand_mode = 1'b0;
    ready_fixed = 1'b1;

    // asynchronous reset mid-stream, then a fresh run
    do_start();
    for (int i = 0; i < 4; i++) wr_pair(8'hE1 + 8'(i), 8'hF1 + 8'(i), 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_ni = 1'b0;
    #1 check("async_reset", {12'd0, wr_ready, fill_req, done, out_valid, a_o, b_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {29'd0, fill_req, out_valid, done}, 32'd0);
    do_start();
    wr_pair(8'h01, 8'h02, 1'b1);
    for (int i = 0; i < 4; i++) wr_pair(8'h03 + 8'(i), 8'h13 + 8'(i), (i == 3));
    wait_done();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
